voice_mix_sequencer: RTL and testbench

- Time-multiplexes one shared waveform ROM across all active voices, once per audio sample period.
- On each sample tick it snapshots the voice list from the address generator (active voice indices, voice count, per-note addresses).
- It issues one ROM read per active voice, accumulates the returned samples, and emits one mixed sample with a valid pulse.
- Sits between the address generator and the output DAC/PWM stage.

---
 rtl/voice_mix_sequencer.sv | 173 +++++++++++++++++
 tb/tb_voice_mix_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/voice_mix_sequencer.sv
// Shares one waveform ROM across all active voices each sample period: it snapshots
// the voice list on a tick, issues one read per voice and emits the summed sample.
module voice_mix_sequencer #(
    parameter int ADDR_WIDTH     = 8,
    parameter int NUM_NOTES      = 24,
    parameter int NUM_VOICES     = 8,
    parameter int NOTE_IDX_WIDTH = 5,
    parameter int SAMPLE_WIDTH   = 8,
    parameter int ROM_LATENCY    = 2
) (
    input  logic                                          clk_in,
    input  logic                                          rst_in,
    input  logic                                          sample_tick_in,
    input  logic [NUM_NOTES-1:0][ADDR_WIDTH-1:0]          addr_in,
    input  logic [3:0]                                    num_voices_in,
    input  logic [NUM_VOICES-1:0][NOTE_IDX_WIDTH-1:0]     active_voices_idx_in,
    output logic                                          rom_en_out,
    output logic [ADDR_WIDTH-1:0]                         rom_addr_out,
    output logic [1:0]                                    rom_sel_out,
    input  logic [SAMPLE_WIDTH-1:0]                       rom_data_in,
    output logic [SAMPLE_WIDTH+2:0]                       mix_out,
    output logic                                          mix_valid_out,
    output logic                                          busy_out,
    output logic                                          overrun_out
);

    localparam int MIX_W  = SAMPLE_WIDTH + 3;
    localparam int SLOT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int DRN_W  = $clog2(ROM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t                                state, state_nxt;
    logic [NUM_VOICES-1:0][ADDR_WIDTH-1:0] look_addr, snap_addr;
    logic [NUM_VOICES-1:0]                 look_valid, snap_valid;
    logic [NUM_VOICES-1:0][1:0]            look_sel, snap_sel;
    logic [3:0]                            n_in, n_r;
    logic [SLOT_W-1:0]                     slot, slot_inc;
    logic [DRN_W-1:0]                      drain_cnt;
    logic [ROM_LATENCY-1:0]                rd_vld;
    logic [MIX_W-1:0]                      acc, acc_nxt;
    logic                                  tick_ok, tick_drop, slot_last;
    logic                                  rom_en_nxt;
    logic [ADDR_WIDTH-1:0]                 rom_addr_nxt;
    logic [1:0]                            rom_sel_nxt;

    assign n_in      = (num_voices_in > 4'(NUM_VOICES)) ? 4'(NUM_VOICES) : num_voices_in;
    assign tick_ok   = sample_tick_in && ((state == IDLE) || (state == DONE));
    assign tick_drop = sample_tick_in && ((state == ISSUE) || (state == DRAIN));
    assign slot_last = (4'(slot) == (n_r - 4'd1));
    assign slot_inc  = slot + SLOT_W'(1);
    assign acc_nxt   = acc + (rd_vld[ROM_LATENCY-1] ? MIX_W'(rom_data_in) : MIX_W'(0));

    // Per-slot note lookup on the live inputs; a mux-free OR keeps out-of-range indices at zero.
    always_comb begin
        for (int k = 0; k < NUM_VOICES; k++) begin
            look_valid[k] = (active_voices_idx_in[k] < NOTE_IDX_WIDTH'(NUM_NOTES));
            look_sel[k]   = 2'(active_voices_idx_in[k] >> 3);
            look_addr[k]  = '0;
            for (int j = 0; j < NUM_NOTES; j++) begin
                look_addr[k] = look_addr[k] |
                    ((active_voices_idx_in[k] == NOTE_IDX_WIDTH'(j)) ? addr_in[j] : ADDR_WIDTH'(0));
            end
        end
    end

    // Next state and next ROM request; slot 0 is taken straight from the inputs at the tick.
    always_comb begin
        state_nxt    = state;
        rom_en_nxt   = 1'b0;
        rom_addr_nxt = '0;
        rom_sel_nxt  = 2'b00;
        case (state)
            IDLE, DONE: begin
                if (sample_tick_in) begin
                    if (n_in == 4'd0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt    = ISSUE;
                        rom_en_nxt   = look_valid[0];
                        rom_addr_nxt = look_addr[0];
                        rom_sel_nxt  = look_sel[0];
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                if (slot_last) begin
                    state_nxt = DRAIN;
                end else begin
                    state_nxt    = ISSUE;
                    rom_en_nxt   = snap_valid[slot_inc];
                    rom_addr_nxt = snap_addr[slot_inc];
                    rom_sel_nxt  = snap_sel[slot_inc];
                end
            end
            DRAIN: begin
                if (drain_cnt == DRN_W'(0)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = DRAIN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Snapshot, issue counters, read-return pipeline, accumulator and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            n_r           <= 4'd0;
            snap_addr     <= '0;
            snap_valid    <= '0;
            snap_sel      <= '0;
            slot          <= '0;
            drain_cnt     <= '0;
            rd_vld        <= '0;
            acc           <= '0;
            mix_out       <= '0;
            mix_valid_out <= 1'b0;
            busy_out      <= 1'b0;
            overrun_out   <= 1'b0;
            rom_en_out    <= 1'b0;
            rom_addr_out  <= '0;
            rom_sel_out   <= 2'b00;
        end else begin
            rom_en_out    <= rom_en_nxt;
            rom_addr_out  <= rom_addr_nxt;
            rom_sel_out   <= rom_sel_nxt;
            busy_out      <= (state_nxt == ISSUE) || (state_nxt == DRAIN);
            mix_valid_out <= (state_nxt == DONE);
            overrun_out   <= overrun_out | tick_drop;
            rd_vld[0]     <= rom_en_out;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                rd_vld[i] <= rd_vld[i-1];
            end
            if (tick_ok) begin
                n_r        <= n_in;
                snap_addr  <= look_addr;
                snap_valid <= look_valid;
                snap_sel   <= look_sel;
                slot       <= '0;
                acc        <= '0;
            end else begin
                acc <= acc_nxt;
                if (state == ISSUE) begin
                    slot <= slot_inc;
                end
            end
            if (state == ISSUE) begin
                drain_cnt <= DRN_W'(ROM_LATENCY - 1);
            end else if ((state == DRAIN) && (drain_cnt != DRN_W'(0))) begin
                drain_cnt <= drain_cnt - DRN_W'(1);
            end
            if (tick_ok && (n_in == 4'd0)) begin
                mix_out <= '0;
            end else if ((state == DRAIN) && (drain_cnt == DRN_W'(0))) begin
                mix_out <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_voice_mix_sequencer.sv
// Directed and randomized bench for voice_mix_sequencer: a 2-cycle ROM model plus a
// per-mix reference computed from the voice list (expected reads, sum and result cycle).
module tb_voice_mix_sequencer;

    localparam int AW = 8, NN = 24, NV = 8, IW = 5, SW = 8, RL = 2;

    logic                    clk_in = 1'b0;
    logic                    rst_in;
    logic                    sample_tick_in;
    logic [NN-1:0][AW-1:0]   addr_in;
    logic [3:0]              num_voices_in;
    logic [NV-1:0][IW-1:0]   active_voices_idx_in;
    logic                    rom_en_out;
    logic [AW-1:0]           rom_addr_out;
    logic [1:0]              rom_sel_out;
    logic [SW-1:0]           rom_data_in;
    logic [SW+2:0]           mix_out;
    logic                    mix_valid_out;
    logic                    busy_out;
    logic                    overrun_out;

    int      n_cmp = 0;
    int      n_bad = 0;
    int      rom_mode = 0;
    bit      exp_ovr = 1'b0;
    logic [SW-1:0] rom_d1;

    voice_mix_sequencer #(
        .ADDR_WIDTH(AW), .NUM_NOTES(NN), .NUM_VOICES(NV),
        .NOTE_IDX_WIDTH(IW), .SAMPLE_WIDTH(SW), .ROM_LATENCY(RL)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .sample_tick_in(sample_tick_in),
        .addr_in(addr_in), .num_voices_in(num_voices_in),
        .active_voices_idx_in(active_voices_idx_in),
        .rom_en_out(rom_en_out), .rom_addr_out(rom_addr_out), .rom_sel_out(rom_sel_out),
        .rom_data_in(rom_data_in), .mix_out(mix_out), .mix_valid_out(mix_valid_out),
        .busy_out(busy_out), .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] rom_fn(input int mode, input logic [1:0] sel, input logic [7:0] a);
        case (mode)
            0:       return a;
            1:       return 8'hAA;
            default: return a ^ {sel, sel, sel, sel};
        endcase
    endfunction

    // ROM model: data appears two cycles after the strobe; junk otherwise.
    always @(posedge clk_in) begin
        rom_d1      <= (rom_en_out || rom_mode == 1) ? rom_fn(rom_mode, rom_sel_out, rom_addr_out)
                                                     : 8'($urandom);
        rom_data_in <= rom_d1;
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        num_voices_in = 4'($urandom);
        for (int k = 0; k < NV; k++) active_voices_idx_in[k] = 5'($urandom);
        for (int j = 0; j < NN; j++) addr_in[j] = 8'($urandom);
    endtask

    task automatic rand_cfg();
        num_voices_in = 4'($urandom_range(0, 15));
        for (int k = 0; k < NV; k++)
            active_voices_idx_in[k] = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(24, 31))
                                                                 : 5'($urandom_range(0, 23));
        for (int j = 0; j < NN; j++) addr_in[j] = 8'($urandom);
    endtask

    // Tick now, then check every cycle up to the result; drop_at<0 picks a random drop tick.
    task automatic run_mix(input int drop_at, input bit b2b);
        int n, lat, sum, drop;
        bit exp_en [NV];
        int exp_addr [NV];
        int exp_sel [NV];
        n   = (num_voices_in > 4'd8) ? 8 : int'(num_voices_in);
        sum = 0;
        for (int k = 0; k < NV; k++) begin
            int id;
            id = int'(active_voices_idx_in[k]);
            exp_en[k]   = (k < n) && (id < NN);
            exp_addr[k] = (id < NN) ? int'(addr_in[id]) : 0;
            exp_sel[k]  = id / 8;
            if (exp_en[k]) sum += int'(rom_fn(rom_mode, 2'(exp_sel[k]), 8'(exp_addr[k])));
        end
        lat  = (n == 0) ? 1 : n + RL + 1;
        drop = drop_at;
        if (drop < 0) drop = (lat > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, lat - 1) : 0;
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        scramble();
        for (int c = 1; c <= lat; c++) begin
            chk("rom_en", 32'(rom_en_out), (c <= n) ? 32'(exp_en[c-1]) : 32'd0);
            if (c <= n && exp_en[c-1]) begin
                chk("rom_addr", 32'(rom_addr_out), 32'(exp_addr[c-1]));
                chk("rom_sel", 32'(rom_sel_out), 32'(exp_sel[c-1]));
            end
            chk("busy", 32'(busy_out), 32'(c < lat));
            chk("mix_valid", 32'(mix_valid_out), 32'(c == lat));
            if (c == lat) chk("mix_out", 32'(mix_out), 32'(sum));
            sample_tick_in = (c == drop);
            if (c == drop) exp_ovr = 1'b1;
            if (c < lat) step();
        end
        sample_tick_in = 1'b0;
        chk("overrun", 32'(overrun_out), 32'(exp_ovr));
        if (!b2b) begin
            step();
            chk("valid_pulse_len", 32'(mix_valid_out), 32'd0);
            chk("mix_hold", 32'(mix_out), 32'(sum));
            chk("idle_busy", 32'(busy_out), 32'd0);
        end
    endtask

    initial begin
        rst_in = 1'b1;
        sample_tick_in = 1'b0;
        num_voices_in = 4'd0;
        active_voices_idx_in = '0;
        addr_in = '0;
        rom_mode = 1;
        step();

        // Reset held three cycles with ROM driving 0xAA and a tick applied.
        for (int i = 0; i < 3; i++) begin
            sample_tick_in = 1'b1;
            num_voices_in = 4'd3;
            step();
            chk("rst_mix", 32'(mix_out), 32'd0);
            chk("rst_valid", 32'(mix_valid_out), 32'd0);
            chk("rst_busy", 32'(busy_out), 32'd0);
            chk("rst_ovr", 32'(overrun_out), 32'd0);
            chk("rst_en", 32'(rom_en_out), 32'd0);
            chk("rst_addr", 32'(rom_addr_out), 32'd0);
            chk("rst_sel", 32'(rom_sel_out), 32'd0);
        end
        rst_in = 1'b0;
        sample_tick_in = 1'b0;
        num_voices_in = 4'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_valid", 32'(mix_valid_out), 32'd0);
            chk("post_rst_en", 32'(rom_en_out), 32'd0);
        end

        // One voice, data = address.
        rom_mode = 0;
        num_voices_in = 4'd1;
        active_voices_idx_in[0] = 5'd3;
        addr_in[3] = 8'h40;
        run_mix(0, 1'b0);

        // Full load, all addresses 0xFF.
        num_voices_in = 4'd8;
        active_voices_idx_in = {5'd23, 5'd20, 5'd19, 5'd16, 5'd11, 5'd8, 5'd3, 5'd0};
        for (int j = 0; j < NN; j++) addr_in[j] = 8'hFF;
        run_mix(0, 1'b0);

        // Zero voices.
        num_voices_in = 4'd0;
        run_mix(0, 1'b0);

        // Clamp to 8, invalid slot 2, dropped tick at T+4.
        num_voices_in = 4'd12;
        for (int k = 0; k < NV; k++) active_voices_idx_in[k] = 5'($urandom_range(0, 23));
        active_voices_idx_in[2] = 5'd31;
        for (int j = 0; j < NN; j++) addr_in[j] = 8'h10;
        run_mix(4, 1'b0);

        // Reset in cycle T+3 of an 8-voice mix, then an immediate fresh mix.
        rom_mode = 2;
        num_voices_in = 4'd8;
        for (int k = 0; k < NV; k++) active_voices_idx_in[k] = 5'($urandom_range(0, 23));
        for (int j = 0; j < NN; j++) addr_in[j] = 8'($urandom);
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        step();
        step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        exp_ovr = 1'b0;
        chk("midrst_valid", 32'(mix_valid_out), 32'd0);
        chk("midrst_busy", 32'(busy_out), 32'd0);
        chk("midrst_en", 32'(rom_en_out), 32'd0);
        chk("midrst_mix", 32'(mix_out), 32'd0);
        chk("midrst_ovr", 32'(overrun_out), 32'd0);
        num_voices_in = 4'd8;
        for (int k = 0; k < NV; k++) active_voices_idx_in[k] = 5'($urandom_range(0, 23));
        for (int j = 0; j < NN; j++) addr_in[j] = 8'($urandom);
        run_mix(0, 1'b0);

        // Randomized mixes, some back-to-back with the tick in the result cycle.
        for (int r = 0; r < 40; r++) begin
            rand_cfg();
            run_mix(-1, 1'($urandom_range(0, 1)));
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
